// File: rtl/seg7_scan_decoder_if.sv
// Display-side bus of the seven-segment scan decoder: the pins being observed
// and the decoded frame word presented to downstream logic.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic [4*NUM_DIGITS-1:0] hex_val;
  logic [NUM_DIGITS-1:0]   dp_val;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    changed;

  // Side that drives the display pins and consumes decoded frames.
  modport master (
    output an, seg,
    input  hex_val, dp_val, digit_err, frame_valid, changed
  );

  // The decoder: watches the pins, produces decoded frames.
  modport slave (
    input  an, seg,
    output hex_val, dp_val, digit_err, frame_valid, changed
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed active-low display bus,
// waits for each digit to settle, decodes glyphs back to nibbles and publishes
// a full word once every digit has been captured.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_decoder_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_CYCLES);

  // Returns {legal, nibble}; anything outside the glyph set (blank included) is illegal.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'h40:   decode_glyph = 5'h10;
      7'h79:   decode_glyph = 5'h11;
      7'h24:   decode_glyph = 5'h12;
      7'h30:   decode_glyph = 5'h13;
      7'h19:   decode_glyph = 5'h14;
      7'h12:   decode_glyph = 5'h15;
      7'h02:   decode_glyph = 5'h16;
      7'h78:   decode_glyph = 5'h17;
      7'h00:   decode_glyph = 5'h18;
      7'h10:   decode_glyph = 5'h19;
      7'h08:   decode_glyph = 5'h1A;
      7'h03:   decode_glyph = 5'h1B;
      7'h46:   decode_glyph = 5'h1C;
      7'h21:   decode_glyph = 5'h1D;
      7'h06:   decode_glyph = 5'h1E;
      7'h0E:   decode_glyph = 5'h1F;
      default: decode_glyph = 5'h00;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0]   s_an_q, p_an_q;
  logic [7:0]              s_seg_q, p_seg_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    active, differ, strobe;
  logic [NUM_DIGITS-1:0]   cap_vec;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] stage_hex_q, stage_hex_d;
  logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic [NUM_DIGITS-1:0]   stage_err_q, stage_err_d;
  logic [4*NUM_DIGITS-1:0] hex_val_q;
  logic [NUM_DIGITS-1:0]   dp_val_q, digit_err_q;
  logic                    frame_valid_q, changed_q;

  // Input sampling plus a one-deep history used to detect a changing bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_an_q  <= '1;
      s_seg_q <= 8'hFF;
      p_an_q  <= '1;
      p_seg_q <= 8'hFF;
    end else begin
      s_an_q  <= bus.an;
      s_seg_q <= bus.seg;
      p_an_q  <= s_an_q;
      p_seg_q <= s_seg_q;
    end
  end

  assign active = $onehot(~s_an_q);
  assign differ = {s_an_q, s_seg_q} != {p_an_q, p_seg_q};
  assign dec    = decode_glyph(s_seg_q[6:0]);
  assign commit = &mask_q;

  // Stability counter holds the current run length (1 on the first sample of
  // a new pattern) so the strobe lands on exactly the STABLE_CYCLES-th sample.
  always_comb begin
    cnt_d  = cnt_q;
    strobe = 1'b0;
    if (!active) begin
      cnt_d = '0;
    end else if (differ) begin
      cnt_d  = CNT_ONE;
      strobe = (STABLE_CYCLES == 1);
    end else if (cnt_q < CNT_STABLE) begin
      cnt_d  = cnt_q + CNT_ONE;
      strobe = (cnt_q + CNT_ONE) == CNT_STABLE;
    end
  end

  // An active sample has exactly one low anode, so its inverse is the digit's capture bit.
  assign cap_vec = strobe ? ~s_an_q : '0;
  assign mask_d  = (commit ? '0 : mask_q) | cap_vec;

  // Staging update for the captured digit; an illegal glyph keeps the old nibble.
  always_comb begin
    stage_hex_d = stage_hex_q;
    stage_dp_d  = stage_dp_q;
    stage_err_d = stage_err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_vec[i]) begin
        stage_dp_d[i]  = ~s_seg_q[7];
        stage_err_d[i] = ~dec[4];
        if (dec[4]) begin
          stage_hex_d[4*i +: 4] = dec[3:0];
        end
      end
    end
  end

  // Counter, capture mask and staging registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      mask_q      <= '0;
      stage_hex_q <= '0;
      stage_dp_q  <= '0;
      stage_err_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      stage_hex_q <= stage_hex_d;
      stage_dp_q  <= stage_dp_d;
      stage_err_q <= stage_err_d;
    end
  end

  // Frame commit: outputs take the staged frame and pulse frame_valid/changed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_val_q     <= '0;
      dp_val_q      <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      changed_q     <= 1'b0;
    end else begin
      frame_valid_q <= commit;
      changed_q     <= commit && (stage_hex_q != hex_val_q);
      if (commit) begin
        hex_val_q   <= stage_hex_q;
        dp_val_q    <= stage_dp_q;
        digit_err_q <= stage_err_q;
      end
    end
  end

  assign bus.hex_val     = hex_val_q;
  assign bus.dp_val      = dp_val_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.changed     = changed_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for the seven-segment scan decoder (4 digits, 4-cycle settle).
module tb_seg7_scan_decoder;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   fv_count = 0;
  logic last_changed = 1'b0;
  int   fv0;

  // Frame pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_count = fv_count + 1;
      last_changed = bus.changed;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [ND-1:0] an_for(input int k);
    logic [ND-1:0] one;
    one = ND'(1);
    return ~(one << k);
  endfunction

  task automatic drive(input logic [ND-1:0] a, input logic [7:0] s, input int cycles);
    @(negedge clk);
    bus.an  = a;
    bus.seg = s;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    drive('1, 8'hFF, cycles);
  endtask

  task automatic show(input int k, input logic [3:0] n, input logic dp, input int cycles);
    drive(an_for(k), {~dp, glyph(n)}, cycles);
  endtask

  task automatic scan(input logic [15:0] val, input logic [3:0] dp, input int dwell);
    for (int k = 0; k < ND; k++) show(k, val[4*k +: 4], dp[k], dwell);
    idle(6);
    #1;
    $display("scan val=%h dp=%b dwell=%0d -> hex_val=%h dp_val=%b digit_err=%b frames=%0d",
             val, dp, dwell, bus.hex_val, bus.dp_val, bus.digit_err, fv_count - fv0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.an = '1;
    bus.seg = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (bus.hex_val !== 16'h0) begin errors++; $display("FAIL reset_hex got %h exp 0000", bus.hex_val); end
    checks++; if (bus.dp_val !== 4'b0) begin errors++; $display("FAIL reset_dp got %b exp 0000", bus.dp_val); end
    checks++; if (bus.digit_err !== 4'b0) begin errors++; $display("FAIL reset_err got %b exp 0000", bus.digit_err); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", bus.frame_valid); end
    checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b exp 0", bus.changed); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_clean_scan();
    fv0 = fv_count;
    scan(16'h1A3F, 4'b0100, 16);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL clean_frames got %0d exp 1", fv_count - fv0); end
    checks++; if (bus.hex_val !== 16'h1A3F) begin errors++; $display("FAIL clean_hex got %h exp 1a3f", bus.hex_val); end
    checks++; if (bus.dp_val !== 4'b0100) begin errors++; $display("FAIL clean_dp got %b exp 0100", bus.dp_val); end
    checks++; if (bus.digit_err !== 4'b0000) begin errors++; $display("FAIL clean_err got %b exp 0000", bus.digit_err); end
    checks++; if (last_changed !== 1'b1) begin errors++; $display("FAIL clean_changed got %b exp 1", last_changed); end
  endtask

  task automatic test_back_to_back();
    fv0 = fv_count;
    scan(16'h1A3F, 4'b0100, 16);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL repeat_frames got %0d exp 1", fv_count - fv0); end
    checks++; if (last_changed !== 1'b0) begin errors++; $display("FAIL repeat_changed got %b exp 0", last_changed); end
    checks++; if (bus.hex_val !== 16'h1A3F) begin errors++; $display("FAIL repeat_hex got %h exp 1a3f", bus.hex_val); end
  endtask

  task automatic test_glitch();
    fv0 = fv_count;
    idle(10);
    drive(an_for(0), 8'hF9, 3);
    idle(10);
    for (int k = 1; k < ND; k++) show(k, 4'h0, 1'b0, 16);
    idle(6);
    #1;
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL glitch_no_frame got %0d exp 0", fv_count - fv0); end
    show(0, 4'h0, 1'b0, 16);
    idle(6);
    #1;
    $display("glitch then scan 0000 -> hex_val=%h frames=%0d", bus.hex_val, fv_count - fv0);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL glitch_frames got %0d exp 1", fv_count - fv0); end
    checks++; if (bus.hex_val !== 16'h0000) begin errors++; $display("FAIL glitch_hex got %h exp 0000", bus.hex_val); end
    checks++; if (last_changed !== 1'b1) begin errors++; $display("FAIL glitch_changed got %b exp 1", last_changed); end
  endtask

  task automatic test_min_dwell();
    fv0 = fv_count;
    scan(16'h1111, 4'b0000, 3);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL short_dwell_frames got %0d exp 0", fv_count - fv0); end
    fv0 = fv_count;
    scan(16'h8765, 4'b0000, 4);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL min_dwell_frames got %0d exp 1", fv_count - fv0); end
    checks++; if (bus.hex_val !== 16'h8765) begin errors++; $display("FAIL min_dwell_hex got %h exp 8765", bus.hex_val); end
  endtask

  task automatic test_double_anode();
    fv0 = fv_count;
    show(0, 4'h2, 1'b0, 16);
    show(1, 4'h4, 1'b0, 16);
    show(2, 4'h6, 1'b0, 16);
    drive(4'b0011, {1'b1, glyph(4'h5)}, 20);
    #1;
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL double_no_frame got %0d exp 0", fv_count - fv0); end
    show(3, 4'h7, 1'b0, 16);
    idle(6);
    #1;
    $display("double anode then digit3 -> hex_val=%h frames=%0d", bus.hex_val, fv_count - fv0);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL double_frames got %0d exp 1", fv_count - fv0); end
    checks++; if (bus.hex_val !== 16'h7642) begin errors++; $display("FAIL double_hex got %h exp 7642", bus.hex_val); end
  endtask

  task automatic test_illegal_glyph();
    fv0 = fv_count;
    for (int k = 0; k < 3; k++) show(k, 4'h8, 1'b0, 16);
    drive(an_for(3), 8'hFF, 16);
    idle(6);
    #1;
    $display("illegal glyph on digit3 -> hex_val=%h digit_err=%b frames=%0d", bus.hex_val, bus.digit_err, fv_count - fv0);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL illegal_frames got %0d exp 1", fv_count - fv0); end
    checks++; if (bus.hex_val !== 16'h7888) begin errors++; $display("FAIL illegal_hex got %h exp 7888", bus.hex_val); end
    checks++; if (bus.digit_err !== 4'b1000) begin errors++; $display("FAIL illegal_err got %b exp 1000", bus.digit_err); end
    checks++; if (last_changed !== 1'b1) begin errors++; $display("FAIL illegal_changed got %b exp 1", last_changed); end
  endtask

  task automatic test_reset_mid_frame();
    fv0 = fv_count;
    for (int k = 0; k < 3; k++) show(k, 4'h9, 1'b0, 16);
    @(negedge clk);
    bus.an = '1;
    bus.seg = 8'hFF;
    rst = 1'b1;
    #1;
    checks++; if (bus.hex_val !== 16'h0) begin errors++; $display("FAIL midrst_hex got %h exp 0000", bus.hex_val); end
    checks++; if (bus.dp_val !== 4'b0) begin errors++; $display("FAIL midrst_dp got %b exp 0000", bus.dp_val); end
    checks++; if (bus.digit_err !== 4'b0) begin errors++; $display("FAIL midrst_err got %b exp 0000", bus.digit_err); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL midrst_fv got %b exp 0", bus.frame_valid); end
    checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL midrst_changed got %b exp 0", bus.changed); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4);
    show(3, 4'hB, 1'b0, 16);
    idle(6);
    #1;
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL midrst_partial got %0d exp 0", fv_count - fv0); end
    show(0, 4'hC, 1'b1, 16);
    show(1, 4'hD, 1'b0, 16);
    show(2, 4'hE, 1'b0, 16);
    idle(6);
    #1;
    $display("after reset recapture -> hex_val=%h dp_val=%b frames=%0d", bus.hex_val, bus.dp_val, fv_count - fv0);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL midrst_frames got %0d exp 1", fv_count - fv0); end
    checks++; if (bus.hex_val !== 16'hBEDC) begin errors++; $display("FAIL midrst_hex2 got %h exp bedc", bus.hex_val); end
    checks++; if (bus.dp_val !== 4'b0001) begin errors++; $display("FAIL midrst_dp2 got %b exp 0001", bus.dp_val); end
  endtask

  initial begin
    test_reset();
    test_clean_scan();
    test_back_to_back();
    test_glitch();
    test_min_dwell();
    test_double_anode();
    test_illegal_glyph();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder: monitors a multiplexed, active-low 7-segment display bus (anodes + shared segment lines), waits for each digit's pattern to settle, decodes it back to a hex nibble and the decimal point, and publishes a complete multi-digit word once every digit has been captured in a scan. It sits between the display drive pins and on-chip checking or logging logic. Typical uses are loop-back verification of the display path and reading values from an external board that drives a standard display.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), 1..8
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured, ≥1

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- an  input  NUM_DIGITS  anode enables, active-low, one-hot-low when a digit is lit
- seg  input  8  segment lines, active-low; bit0=a … bit6=g, bit7=DP
- hex_val  output  4*NUM_DIGITS  decoded word; digit k in bits [4k+3:4k]
- dp_val  output  NUM_DIGITS  decimal point per digit, active-high (lit = 1)
- digit_err  output  NUM_DIGITS  1 = last capture of digit k was not a legal hex glyph
- frame_valid  output  1  one-cycle pulse when hex_val/dp_val/digit_err are updated
- changed  output  1  one-cycle pulse coincident with frame_valid when hex_val differs from its previous value

## Operation
- Input stage: an and seg are registered every cycle into s_an, s_seg. Reset value: s_an = all ones, s_seg = 8'hFF.
- Digit select: the sample is active only when exactly one bit of s_an is 0, giving index k. If zero or multiple bits are low, the sample is idle: no capture occurs and the stability counter is held at 0.
- Stability counter cnt: width clog2(STABLE_CYCLES)+1.
  - Cleared when {s_an,s_seg} differs from the previous sample, or when the sample is idle.
  - Otherwise increments and saturates at STABLE_CYCLES.
  - A capture strobe fires in the single cycle where the active sample has been identical for STABLE_CYCLES consecutive cycles. It fires exactly once per dwell, however long the dwell lasts.
- Capture of digit k:
  - stage_dp[k] = ~s_seg[7].
  - s_seg[6:0] is decoded by the inverse glyph table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex, segments a..g, active-low).
  - Match: stage_hex[k] = nibble, stage_err[k] = 0.
  - No match, including blank 7F: stage_hex[k] keeps its previous value, stage_err[k] = 1.
  - mask[k] set to 1. Recapturing a digit before the frame completes overwrites its staging; mask is unchanged.
- Commit: when mask is all ones, on the next edge:
  - hex_val, dp_val and digit_err load from staging.
  - frame_valid = 1 for one cycle.
  - changed = 1 if the new hex_val ≠ the old hex_val.
  - mask is cleared.
- A capture in the commit cycle survives: mask_next = (commit ? 0 : mask) | capture_bit. Staging written in that cycle belongs to the next frame.
- Reset mid-operation: all state returns to reset values immediately. A partially captured frame is discarded and no frame_valid is produced.

## Timing
- Reset values:
  - hex_val = 0, dp_val = 0, digit_err = 0, frame_valid = 0, changed = 0.
  - mask = 0, cnt = 0, staging all 0.
- Capture latency: a pattern first present on the pins before edge n and held unchanged is written to staging at edge n+STABLE_CYCLES.
- Commit latency: outputs update, and frame_valid rises, one edge after the staging write that completes the mask.
- Minimum dwell per digit for capture: STABLE_CYCLES cycles. Shorter glitches are ignored.
- No back-pressure: frame_valid is a pulse. Outputs hold their values between commits.

## Test plan
- Clean scan, NUM_DIGITS=4, STABLE_CYCLES=4, 16-cycle dwell per digit, display 0x1A3F with DP on digit 2 -> exactly one frame_valid, hex_val=16'h1A3F, dp_val=4'b0100, digit_err=0, changed=1.
- Repeat the identical scan -> frame_valid=1, changed=0, hex_val unchanged.
- 3-cycle glitch of pattern 0x79 on digit 0 inside an idle gap, then a normal scan of 0x0000 -> glitch never captured; hex_val=16'h0000.
- Illegal glyph 7'h7F on digit 3 with the others showing 8 -> digit_err=4'b1000; hex_val[15:12] keeps its prior value; the frame still commits.
- Two anodes low simultaneously for 20 cycles -> no capture, mask unchanged, no frame_valid.
- Assert rst after three of four digits are captured, then release -> outputs all 0; the next commit needs all four digits recaptured.
